// File: rtl/wb_port_arbiter_pkg.sv
// Shared pipeline constants and the MDU result FIFO entry layout
// used by the writeback-port arbiter and its result FIFO.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // live is cleared when a younger writeback to the same register cancels the entry
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } fifo_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular FIFO holding MDU results until an idle writeback slot drains them.
// Entries can be cancelled by destination register and expose live/reg views.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 push,
    input  fifo_entry_t                          push_entry,
    input  logic                                 pop,
    input  logic                                 cancel_en,
    input  logic [REG_ADDR_W-1:0]                cancel_reg,
    output fifo_entry_t                          head,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH-1:0]                     live_vec,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     reg_vec
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t            mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;

    // Popped slots lose live so live alone marks a pending result.
    // The push write comes last so a same-cycle enqueue is never cancelled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cancel_en && (mem[i].dst == cancel_reg)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

    always_comb begin
        live_vec = '0;
        reg_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_vec[i] = mem[i].live;
            reg_vec[i]  = mem[i].dst;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage (always wins)
// and queued MDU results; provides a register-busy scoreboard and starvation stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reg_write_W,
    input  logic [REG_ADDR_W-1:0] write_reg_W,
    input  logic [DATA_W-1:0]     result_W,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_reg,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] query_rs,
    input  logic [REG_ADDR_W-1:0] query_rt,
    output logic                  busy_rs,
    output logic                  busy_rt,
    output logic                  stall_req,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                              wb_active;
    logic                              push;
    logic                              pop;
    logic                              full;
    logic                              empty;
    fifo_entry_t                       head;
    fifo_entry_t                       push_entry;
    logic [DEPTH-1:0]                  live_vec;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  reg_vec;
    logic [CNT_W-1:0]                  starve_cnt;

    // Outputs are gated by reset_n so nothing reaches the register file during reset.
    assign wb_active  = reg_write_W && (write_reg_W != '0);
    assign pop        = reset_n && !wb_active && !empty;
    assign mdu_ready  = reset_n && (!full || pop);
    assign push       = mdu_valid && mdu_ready && (mdu_reg != '0);
    assign push_entry = '{live: 1'b1, dst: mdu_reg, data: mdu_data};

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .cancel_en  (wb_active),
        .cancel_reg (write_reg_W),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .live_vec   (live_vec),
        .reg_vec    (reg_vec)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (reset_n) begin
            if (wb_active) begin
                rf_we    = 1'b1;
                rf_waddr = write_reg_W;
                rf_wdata = result_W;
            end else if (!empty && head.live) begin
                rf_we    = 1'b1;
                rf_waddr = head.dst;
                rf_wdata = head.data;
            end
        end
    end

    always_comb begin
        busy_rs = 1'b0;
        busy_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_vec[i] && (reg_vec[i] == query_rs) && (query_rs != '0)) busy_rs = 1'b1;
            if (live_vec[i] && (reg_vec[i] == query_rt) && (query_rt != '0)) busy_rt = 1'b1;
        end
    end

    // Counts writeback-blocked cycles with results waiting; saturates so the stall holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (wb_active && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign stall_req = (starve_cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        reg_write_W;
    logic [4:0]  write_reg_W;
    logic [31:0] result_W;
    logic        mdu_valid;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  query_rs;
    logic [4:0]  query_rt;
    logic        busy_rs;
    logic        busy_rt;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int          n_checks;
    int          n_fail;
    logic [31:0] rf_shadow [32];

    wb_port_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_write_W (reg_write_W),
        .write_reg_W (write_reg_W),
        .result_W    (result_W),
        .mdu_valid   (mdu_valid),
        .mdu_reg     (mdu_reg),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .query_rs    (query_rs),
        .query_rt    (query_rt),
        .busy_rs     (busy_rs),
        .busy_rt     (busy_rt),
        .stall_req   (stall_req),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file image built from the write port, used for end-state checks.
    always @(posedge clk) begin
        if (rf_we) rf_shadow[rf_waddr] <= rf_wdata;
    end

    task automatic apply_stimulus(input logic wbe, input logic [4:0] wreg, input logic [31:0] wdata,
                                  input logic mv, input logic [4:0] mreg, input logic [31:0] mdata);
        reg_write_W = wbe;
        write_reg_W = wreg;
        result_W    = wdata;
        mdu_valid   = mv;
        mdu_reg     = mreg;
        mdu_data    = mdata;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) rf_shadow[i] = 32'h0;
        reset_n  = 1'b0;
        query_rs = 5'd0;
        query_rt = 5'd0;

        // Reset state, with an active writeback that must be suppressed
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd3, 32'h1);
        check_output("reset_rf_we", rf_we, 0);
        check_output("reset_rf_waddr", rf_waddr, 0);
        check_output("reset_rf_wdata", rf_wdata, 0);
        check_output("reset_mdu_ready", mdu_ready, 0);
        check_output("reset_stall_req", stall_req, 0);
        tick();
        tick();
        reset_n = 1'b1;
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("post_reset_mdu_ready", mdu_ready, 1);
        check_output("post_reset_rf_we", rf_we, 0);

        // Writeback only, zero latency
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check_output("wb_rf_we", rf_we, 1);
        check_output("wb_rf_waddr", rf_waddr, 5);
        check_output("wb_rf_wdata", rf_wdata, 32'hDEADBEEF);
        check_output("wb_mdu_ready", mdu_ready, 1);
        tick();

        // MDU drain one cycle after enqueue
        query_rs = 5'd9;
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234);
        check_output("drain_pre_rf_we", rf_we, 0);
        check_output("drain_pre_busy", busy_rs, 0);
        tick();
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("drain_busy", busy_rs, 1);
        check_output("drain_rf_we", rf_we, 1);
        check_output("drain_rf_waddr", rf_waddr, 9);
        check_output("drain_rf_wdata", rf_wdata, 32'h1234);
        tick();
        check_output("drain_post_busy", busy_rs, 0);
        check_output("drain_post_rf_we", rf_we, 0);

        // Fill the FIFO while writeback holds the port
        query_rs = 5'd10;
        query_rt = 5'd13;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'(10 + i), 32'h100 + 32'(i));
            check_output("fill_mdu_ready", mdu_ready, 1);
            tick();
        end
        apply_stimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd14, 32'h104);
        check_output("full_mdu_ready", mdu_ready, 0);
        check_output("full_rf_waddr", rf_waddr, 1);
        check_output("full_busy_rs", busy_rs, 1);
        check_output("full_busy_rt", busy_rt, 1);
        for (int i = 0; i < 4; i++) tick();
        check_output("starve7_stall", stall_req, 0);
        tick();
        check_output("starve8_stall", stall_req, 1);
        check_output("starve8_mdu_ready", mdu_ready, 0);

        // One idle writeback slot pops the head and admits the held offer
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h104);
        check_output("pop_rf_we", rf_we, 1);
        check_output("pop_rf_waddr", rf_waddr, 10);
        check_output("pop_rf_wdata", rf_wdata, 32'h100);
        check_output("pop_mdu_ready", mdu_ready, 1);
        tick();
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("pop_stall_cleared", stall_req, 0);
        for (int i = 0; i < 4; i++) begin
            check_output("drain_seq_waddr", rf_waddr, 11 + i);
            check_output("drain_seq_wdata", rf_wdata, 32'h101 + 32'(i));
            tick();
        end
        check_output("drain_seq_empty_we", rf_we, 0);

        // WAW: same-cycle enqueue survives, later writeback cancels
        query_rs = 5'd7;
        query_rt = 5'd0;
        apply_stimulus(1'b1, 5'd7, 32'hCCCC, 1'b1, 5'd7, 32'hAAAA);
        tick();
        apply_stimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        check_output("waw_same_cycle_busy", busy_rs, 1);
        tick();
        apply_stimulus(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'h0);
        check_output("waw_wb_wdata", rf_wdata, 32'hBBBB);
        tick();
        apply_stimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        check_output("waw_cancel_busy", busy_rs, 0);
        tick();
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("waw_dead_pop_we", rf_we, 0);
        tick();
        check_output("waw_after_we", rf_we, 0);
        check_output("waw_reg7_final", rf_shadow[7], 32'hBBBB);

        // Register zero results are consumed but never written
        query_rs = 5'd0;
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5555);
        check_output("r0_mdu_ready", mdu_ready, 1);
        tick();
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("r0_rf_we", rf_we, 0);
        tick();
        check_output("r0_rf_we_later", rf_we, 0);

        // Reset with three queued entries discards them
        query_rs = 5'd20;
        query_rt = 5'd22;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'(20 + i), 32'h200 + 32'(i));
            tick();
        end
        apply_stimulus(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0);
        check_output("queued_busy_rs", busy_rs, 1);
        reset_n = 1'b0;
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("midreset_rf_we", rf_we, 0);
        check_output("midreset_busy_rs", busy_rs, 0);
        check_output("midreset_busy_rt", busy_rt, 0);
        check_output("midreset_mdu_ready", mdu_ready, 0);
        tick();
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("post_reset_no_write", rf_we, 0);
            tick();
        end
        check_output("post_reset_reg20", rf_shadow[20], 32'h0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
